// File: rtl/bin_driv.sv
// Binarisation stage: reads gray/RGB pixel words from BRAM, thresholds the
// gray byte and writes back {gray, b, b, b} with b = 0xFF or 0x00, counting
// set pixels. Requests arrive over the shake handshake; status returns on it.
module bin_driv #(
   parameter int unsigned WD_SHK_SYNC = 16,
   parameter int unsigned WD_SHK_DLAY = 15,
   parameter int unsigned WD_BRAM_DAT = 32,
   parameter int unsigned WD_BRAM_WEN = 4,
   parameter int unsigned WD_ERR_INFO = 4
) (
   input  logic                   s_sys_a_clock,
   input  logic                   s_sys_a_reset,
   input  logic                   s_shk_bin_wvalid,
   input  logic [WD_SHK_SYNC-1:0] s_shk_bin_smosi,
   input  logic [WD_SHK_DLAY-1:0] s_shk_bin_dmosi,
   output logic                   s_shk_bin_wready,
   output logic [WD_SHK_SYNC-1:0] s_shk_bin_smiso,
   output logic [WD_SHK_DLAY-1:0] s_shk_bin_dmiso,
   output logic [WD_BRAM_DAT-1:0] m_bram_bin_addr,
   output logic                   m_bram_bin_clk,
   output logic [WD_BRAM_DAT-1:0] m_bram_bin_din,
   input  logic [WD_BRAM_DAT-1:0] m_bram_bin_dout,
   output logic                   m_bram_bin_en,
   output logic                   m_bram_bin_rst,
   output logic [WD_BRAM_WEN-1:0] m_bram_bin_we,
   input  logic [WD_ERR_INFO-1:0] s_err_bin_info1,
   output logic [WD_ERR_INFO-1:0] m_err_bin_info1
);

   localparam int unsigned WD_CNT   = 20;
   localparam int unsigned WD_PHASE = 2;
   localparam int unsigned WD_GRAY  = 8;
   localparam int unsigned MAX_SIZE = 512;
   localparam int unsigned KPIX_LOG = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_SIZE,
      ST_READ,
      ST_BIN,
      ST_WRITE,
      ST_WAIT
   } state_t;

   state_t                 state_q,  state_d;
   logic [WD_PHASE-1:0]    phase_q,  phase_d;
   logic [WD_BRAM_DAT-1:0] addr_q,   addr_d;
   logic [WD_BRAM_DAT-1:0] last_q,   last_d;
   logic [WD_GRAY-1:0]     gray_q,   gray_d;
   logic [WD_BRAM_DAT-1:0] din_q,    din_d;
   logic [WD_BRAM_WEN-1:0] we_q,     we_d;
   logic                   en_q,     en_d;
   logic [WD_CNT-1:0]      count_q,  count_d;
   logic [WD_GRAY-1:0]     thr_q,    thr_d;
   logic                   inv_q,    inv_d;
   logic                   wready_q, wready_d;
   logic [WD_SHK_SYNC-1:0] smiso_q,  smiso_d;
   logic [WD_SHK_DLAY-1:0] dmiso_q,  dmiso_d;

   logic                   hit;
   logic [WD_GRAY-1:0]     bin_byte;
   logic [WD_CNT-1:0]      count_inc;
   logic                   unused_bits;

   // Config bits above inv and the RGB part of the read word are not needed
   assign unused_bits = ^{s_shk_bin_smosi[WD_SHK_SYNC-1:9], m_bram_bin_dout[WD_BRAM_DAT-9:0]};

   // Threshold decision for the captured pixel
   assign hit       = (gray_q >= thr_q) ^ inv_q;
   assign bin_byte  = hit ? 8'hFF : 8'h00;
   assign count_inc = count_q + WD_CNT'(hit);

   // State and datapath registers
   always_ff @(posedge s_sys_a_clock or posedge s_sys_a_reset) begin
      if (s_sys_a_reset) begin
         state_q  <= ST_IDLE;
         phase_q  <= '0;
         addr_q   <= '0;
         last_q   <= '0;
         gray_q   <= '0;
         din_q    <= '0;
         we_q     <= '0;
         en_q     <= 1'b0;
         count_q  <= '0;
         thr_q    <= '0;
         inv_q    <= 1'b0;
         wready_q <= 1'b0;
         smiso_q  <= '0;
         dmiso_q  <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         addr_q   <= addr_d;
         last_q   <= last_d;
         gray_q   <= gray_d;
         din_q    <= din_d;
         we_q     <= we_d;
         en_q     <= en_d;
         count_q  <= count_d;
         thr_q    <= thr_d;
         inv_q    <= inv_d;
         wready_q <= wready_d;
         smiso_q  <= smiso_d;
         dmiso_q  <= dmiso_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      addr_d   = addr_q;
      last_d   = last_q;
      gray_d   = gray_q;
      din_d    = din_q;
      we_d     = '0;
      en_d     = 1'b1;
      count_d  = count_q;
      thr_d    = thr_q;
      inv_d    = inv_q;
      wready_d = wready_q;
      smiso_d  = smiso_q;
      dmiso_d  = dmiso_q;

      case (state_q)
         ST_IDLE: begin
            wready_d = 1'b0;
            state_d  = ST_START;
         end
         ST_START: begin
            if (s_shk_bin_wvalid) begin
               thr_d   = s_shk_bin_smosi[7:0];
               inv_d   = s_shk_bin_smosi[8];
               count_d = '0;
               smiso_d = '0;
               dmiso_d = '0;
               state_d = ST_SIZE;
            end
         end
         ST_SIZE: begin
            if ((s_shk_bin_dmosi == '0) || (s_shk_bin_dmosi > WD_SHK_DLAY'(MAX_SIZE))) begin
               smiso_d[1] = 1'b1;
               smiso_d[0] = 1'b1;
               wready_d   = 1'b1;
               state_d    = ST_WAIT;
            end else begin
               // Last pixel address of the image, size given in 1k-pixel units
               last_d  = (WD_BRAM_DAT'(s_shk_bin_dmosi) << KPIX_LOG) - WD_BRAM_DAT'(1);
               addr_d  = '0;
               phase_d = '0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (phase_q == WD_PHASE'(2)) begin
               gray_d  = m_bram_bin_dout[31:24];
               phase_d = '0;
               state_d = ST_BIN;
            end else begin
               phase_d = phase_q + WD_PHASE'(1);
            end
         end
         ST_BIN: begin
            din_d   = WD_BRAM_DAT'({gray_q, bin_byte, bin_byte, bin_byte});
            count_d = count_inc;
            dmiso_d = count_inc[WD_CNT-1:5];
            we_d    = '1;
            phase_d = '0;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (phase_q == '0) begin
               phase_d = WD_PHASE'(1);
            end else begin
               phase_d = '0;
               addr_d  = addr_q + WD_BRAM_DAT'(1);
               if (addr_q == last_q) begin
                  smiso_d[0] = 1'b1;
                  wready_d   = 1'b1;
                  state_d    = ST_WAIT;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_WAIT: begin
            wready_d   = 1'b1;
            smiso_d[0] = 1'b1;
            if (!s_shk_bin_wvalid) begin
               wready_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output wiring
   assign s_shk_bin_wready = wready_q;
   assign s_shk_bin_smiso  = smiso_q;
   assign s_shk_bin_dmiso  = dmiso_q;
   assign m_bram_bin_addr  = addr_q;
   assign m_bram_bin_clk   = s_sys_a_clock;
   assign m_bram_bin_din   = din_q;
   assign m_bram_bin_en    = en_q;
   assign m_bram_bin_rst   = 1'b0;
   assign m_bram_bin_we    = we_q;
   assign m_err_bin_info1  = s_err_bin_info1 | WD_ERR_INFO'(smiso_q[1]);

endmodule

// File: tb/tb_bin_driv.sv
// Directed + randomized bench for bin_driv with a BRAM model and a
// pixel-level reference model of the thresholding job.
module tb_bin_driv;

   logic        clk;
   logic        rst;
   logic        wvalid;
   logic [15:0] smosi;
   logic [14:0] dmosi;
   logic        wready;
   logic [15:0] smiso;
   logic [14:0] dmiso;
   logic [31:0] baddr;
   logic        bclk;
   logic [31:0] bdin;
   logic [31:0] bdout;
   logic        ben;
   logic        brst;
   logic [3:0]  bwe;
   logic [3:0]  s_err;
   logic [3:0]  m_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [2048];
   logic [31:0] waddr_q [$];
   logic [31:0] wdata_q [$];

   bin_driv dut (
      .s_sys_a_clock    (clk),
      .s_sys_a_reset    (rst),
      .s_shk_bin_wvalid (wvalid),
      .s_shk_bin_smosi  (smosi),
      .s_shk_bin_dmosi  (dmosi),
      .s_shk_bin_wready (wready),
      .s_shk_bin_smiso  (smiso),
      .s_shk_bin_dmiso  (dmiso),
      .m_bram_bin_addr  (baddr),
      .m_bram_bin_clk   (bclk),
      .m_bram_bin_din   (bdin),
      .m_bram_bin_dout  (bdout),
      .m_bram_bin_en    (ben),
      .m_bram_bin_rst   (brst),
      .m_bram_bin_we    (bwe),
      .s_err_bin_info1  (s_err),
      .m_err_bin_info1  (m_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model with one-cycle read latency
   always @(posedge clk) bdout <= mem[baddr[10:0]];

   // Record every full-word write
   always @(posedge clk) begin
      if (!rst && bwe == 4'hF) begin
         waddr_q.push_back(baddr);
         wdata_q.push_back(bdin);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 2048; i++) mem[i] = {8'(i), 24'($urandom)};
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 2048; i++) mem[i] = $urandom;
   endtask

   // One full request: drive, wait for done, compare against the pixel model
   task automatic run_job(input logic [7:0] thr, input logic inv, input logic [14:0] sz,
                          input bit drop_mid, input string tag);
      int n;
      int exp_n;
      int npix;
      int exp_cnt;
      int nbad;
      int first_bad;
      bit err;
      logic [7:0]  g;
      logic        h;
      logic [31:0] exp_word;
      logic [15:0] exp_smiso;
      logic [14:0] exp_dmiso;

      waddr_q.delete();
      wdata_q.delete();
      repeat (2) @(negedge clk);
      s_err  = 4'($urandom);
      smosi  = {7'($urandom), inv, thr};
      dmosi  = sz;
      wvalid = 1'b1;
      err    = (sz == 15'd0) || (sz > 15'd512);
      npix   = err ? 0 : int'(sz) * 1024;
      exp_n  = err ? 2 : 2 + 6 * npix;

      n = 0;
      while (n < exp_n + 64) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (wready) break;
         if (drop_mid && n == 100) wvalid = 1'b0;
      end
      chk({tag, "_latency"}, 64'(n), 64'(exp_n));

      // Reference: threshold each source pixel
      exp_cnt   = 0;
      nbad      = 0;
      first_bad = -1;
      for (int i = 0; i < npix; i++) begin
         g = mem[i][31:24];
         h = (g >= thr) ^ inv;
         exp_cnt += h ? 1 : 0;
         exp_word = {g, h ? 24'hFFFFFF : 24'h000000};
         if (i >= waddr_q.size() || waddr_q[i] !== 32'(i) || wdata_q[i] !== exp_word) begin
            nbad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      chk({tag, "_nwrites"}, 64'(waddr_q.size()), 64'(npix));
      chk({tag, "_bad_words_first_at"}, {32'(nbad), 32'(first_bad)}, {32'd0, 32'hFFFFFFFF});

      exp_smiso = err ? 16'h0003 : 16'h0001;
      exp_dmiso = 15'(exp_cnt / 32);
      chk({tag, "_smiso"}, 64'(smiso), 64'(exp_smiso));
      chk({tag, "_dmiso"}, 64'(dmiso), 64'(exp_dmiso));
      chk({tag, "_merr"},  64'(m_err), 64'(s_err | {3'b000, err}));

      if (!drop_mid) begin
         repeat (10) @(negedge clk);
         chk({tag, "_wready_held"}, 64'(wready), 64'd1);
         wvalid = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_wready_idle"}, 64'(wready), 64'd0);
      chk({tag, "_smiso_kept"},  64'(smiso),  64'(exp_smiso));
      @(negedge clk);
      chk({tag, "_dmiso_kept"},  64'(dmiso),  64'(exp_dmiso));
   endtask

   initial begin
      int n;
      rst    = 1'b1;
      wvalid = 1'b0;
      smosi  = '0;
      dmosi  = '0;
      s_err  = '0;
      #1;
      chk("rst_we",     64'(bwe),    64'd0);
      chk("rst_en",     64'(ben),    64'd0);
      chk("rst_brst",   64'(brst),   64'd0);
      chk("rst_wready", 64'(wready), 64'd0);
      chk("rst_smiso",  64'(smiso),  64'd0);
      chk("rst_dmiso",  64'(dmiso),  64'd0);
      chk("rst_addr",   64'(baddr),  64'd0);
      chk("rst_din",    64'(bdin),   64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("en_after_rst",   64'(ben),  64'd1);
      chk("brst_after_rst", 64'(brst), 64'd0);
      chk("bclk_low",       64'(bclk), 64'(clk));
      #5;
      chk("bclk_high",      64'(bclk), 64'(clk));

      // Ramp image, threshold 0x80, normal and inverted polarity
      fill_ramp();
      run_job(8'h80, 1'b0, 15'd1, 1'b0, "ramp");
      chk("ramp_dmiso_16", 64'(dmiso), 64'd16);
      run_job(8'h80, 1'b1, 15'd1, 1'b0, "ramp_inv");
      chk("ramp_inv_dmiso_16", 64'(dmiso), 64'd16);

      // Illegal sizes
      run_job(8'h10, 1'b0, 15'd0,   1'b0, "size0");
      run_job(8'h10, 1'b0, 15'd513, 1'b0, "size513");

      // Random images and configs, some with wvalid dropped mid-job
      for (int k = 0; k < 3; k++) begin
         fill_rand();
         run_job(8'($urandom), 1'($urandom), (k == 2) ? 15'd2 : 15'd1, (k != 1), "rand");
      end

      // Maximum size accepted; async reset in the middle of a write
      for (int i = 0; i < 2048; i++) mem[i] = {8'hFF, 24'($urandom)};
      waddr_q.delete();
      wdata_q.delete();
      repeat (2) @(negedge clk);
      s_err  = 4'($urandom);
      smosi  = 16'h0000;
      dmosi  = 15'd512;
      wvalid = 1'b1;
      n = 0;
      while (n < 200 && !(bwe == 4'hF && waddr_q.size() >= 3)) begin
         @(negedge clk);
         n++;
      end
      chk("max_we_seen",      64'(bwe),   64'hF);
      chk("max_no_size_err",  64'(smiso), 64'd0);
      chk("max_merr",         64'(m_err), 64'(s_err));
      chk("max_wr_addr",      64'(baddr), 64'(waddr_q.size()));
      chk("max_wr_data",      64'(bdin),  64'hFFFFFFFF);
      rst = 1'b1;
      #1;
      chk("arst_we",     64'(bwe),    64'd0);
      chk("arst_addr",   64'(baddr),  64'd0);
      chk("arst_din",    64'(bdin),   64'd0);
      chk("arst_en",     64'(ben),    64'd0);
      chk("arst_wready", 64'(wready), 64'd0);
      chk("arst_smiso",  64'(smiso),  64'd0);
      chk("arst_dmiso",  64'(dmiso),  64'd0);
      wvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fresh request after reset restarts from address 0
      fill_ramp();
      run_job(8'h40, 1'b0, 15'd1, 1'b0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
